// File: rtl/i2c_wb_arbiter.sv
// Two-port round-robin Wishbone arbiter in front of the I2C master's slave port.
// Grant is held for a whole cyc; a per-access watchdog aborts strobes that are never acked.
module i2c_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic          WD_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_W  = TW'(TIMEOUT);

  // Requester signals packed by port index so the mux and gating can be indexed.
  logic [1:0]       m_cyc;
  logic [1:0]       m_stb;
  logic [1:0]       m_we;
  logic [1:0][3:0]  m_sel;
  logic [1:0][31:0] m_adr;
  logic [1:0][31:0] m_dat;
  logic [1:0]       m_ack;
  logic [1:0]       m_err;

  assign m_cyc = {m1_cyc_i, m0_cyc_i};
  assign m_stb = {m1_stb_i, m0_stb_i};
  assign m_we  = {m1_we_i,  m0_we_i};
  assign m_sel = {m1_sel_i, m0_sel_i};
  assign m_adr = {m1_adr_i, m0_adr_i};
  assign m_dat = {m1_dat_i, m0_dat_i};

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          abort_q, abort_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          s_cyc_q, s_cyc_d;
  logic          s_stb_q, s_stb_d;
  logic          s_we_q, s_we_d;
  logic [3:0]    s_sel_q, s_sel_d;
  logic [31:0]   s_adr_q, s_adr_d;
  logic [31:0]   s_dat_q, s_dat_d;

  logic [1:0]    grant;
  logic          handover;
  logic          timeout_hit;
  logic          nxt_idx;

  always_comb begin
    grant = 2'b00;
    case (state_q)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Arbitration happens only when idle or when the owner has let go of cyc.
  assign handover = (state_q == IDLE) ||
                    ((state_q == GNT0) && !m_cyc[0]) ||
                    ((state_q == GNT1) && !m_cyc[1]);

  // An ack in the same cycle as the limit wins over the abort.
  assign timeout_hit = WD_EN && s_stb_q && !s_ack_i && (cnt_q == TO_W);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    abort_d = abort_q;
    if (handover) begin
      abort_d = 1'b0;
      if (m_cyc[0] && m_cyc[1]) begin
        state_d = last_q ? GNT0 : GNT1;
      end else if (m_cyc[0]) begin
        state_d = GNT0;
      end else if (m_cyc[1]) begin
        state_d = GNT1;
      end else begin
        state_d = IDLE;
      end
      if (state_d == GNT0) begin
        last_d = 1'b0;
      end else if (state_d == GNT1) begin
        last_d = 1'b1;
      end
    end else if (timeout_hit) begin
      abort_d = 1'b1;
    end
  end

  // Slave-side registers follow the owner selected for the next cycle.
  always_comb begin
    nxt_idx = (state_d == GNT1);
    s_cyc_d = 1'b0;
    s_stb_d = 1'b0;
    s_we_d  = s_we_q;
    s_sel_d = s_sel_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    if ((state_d != IDLE) && !abort_d) begin
      s_cyc_d = m_cyc[nxt_idx];
      s_stb_d = m_stb[nxt_idx];
      s_we_d  = m_we[nxt_idx];
      s_sel_d = m_sel[nxt_idx];
      s_adr_d = m_adr[nxt_idx];
      s_dat_d = m_dat[nxt_idx];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!s_stb_q || s_ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  assign timeout_d = timeout_q | timeout_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      s_cyc_q   <= 1'b0;
      s_stb_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      s_cyc_q   <= s_cyc_d;
      s_stb_q   <= s_stb_d;
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_adr_q   <= s_adr_d;
      s_dat_q   <= s_dat_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign m_ack[gi] = s_ack_i && grant[gi] && s_stb_q && !abort_q;
    assign m_err[gi] = timeout_hit && grant[gi];
  end

  assign m0_ack_o  = m_ack[0];
  assign m0_err_o  = m_err[0];
  assign m0_dat_o  = s_dat_i;
  assign m1_ack_o  = m_ack[1];
  assign m1_err_o  = m_err[1];
  assign m1_dat_o  = s_dat_i;

  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign s_sel_o   = s_sel_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;

  assign grant_o   = grant;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Directed bench for i2c_wb_arbiter: main instance with TIMEOUT=10, a second with the
// watchdog disabled sharing the same stimulus.
module tb_i2c_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        s_ack;
  logic [31:0] s_rdat;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, tmo;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [1:0]  grant;

  logic        nt_m0_ack, nt_m0_err, nt_m1_ack, nt_m1_err;
  logic [31:0] nt_m0_rdat, nt_m1_rdat;
  logic        nt_s_cyc, nt_s_stb, nt_s_we, nt_tmo;
  logic [3:0]  nt_s_sel;
  logic [31:0] nt_s_adr, nt_s_wdat;
  logic [1:0]  nt_grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_wb_arbiter #(.TIMEOUT(10), .TW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .timeout_o(tmo)
  );

  i2c_wb_arbiter #(.TIMEOUT(0), .TW(8)) dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(nt_m0_ack), .m0_err_o(nt_m0_err), .m0_dat_o(nt_m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(nt_m1_ack), .m1_err_o(nt_m1_err), .m1_dat_o(nt_m1_rdat),
    .s_cyc_o(nt_s_cyc), .s_stb_o(nt_s_stb), .s_we_o(nt_s_we), .s_sel_o(nt_s_sel),
    .s_adr_o(nt_s_adr), .s_dat_o(nt_s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(nt_grant), .timeout_o(nt_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = '0; m1_dat = '0;
    s_ack  = 1'b0;
  endtask

  task automatic drive_m0(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat = dat;
  endtask

  task automatic drive_m1(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat = dat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    n_checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {s_cyc, s_stb, s_we}); end
    n_checks++; if ({s_sel, s_adr, s_wdat} !== 68'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {s_sel, s_adr, s_wdat}); end
    n_checks++; if ({grant, tmo} !== 3'b000) begin n_fail++; $display("FAIL reset_grant_tmo: got %b expected 000", {grant, tmo}); end
    n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_tie();
    for (int r = 0; r < 2; r++) begin
      tick();
      drive_m0(1'b1, 32'h100 + r, 32'hA0 + r);
      drive_m1(1'b0, 32'h200 + r, 32'hB0 + r);
      tick();
      s_ack = 1'b1;
      #1;
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_grant_m0 round %0d: got %b expected 01", r, grant); end
      n_checks++; if ({s_adr, s_wdat} !== {32'h100 + r, 32'hA0 + r}) begin n_fail++; $display("FAIL tie_m0_payload round %0d: got %h expected %h", r, {s_adr, s_wdat}, {32'h100 + r, 32'hA0 + r}); end
      n_checks++; if ({m0_ack, m1_ack} !== 2'b10) begin n_fail++; $display("FAIL tie_m0_ack round %0d: got %b expected 10", r, {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      n_checks++; if ({grant, s_adr} !== {2'b01, 32'h100 + r}) begin n_fail++; $display("FAIL tie_m0_hold round %0d: got %h expected %h", r, {grant, s_adr}, {2'b01, 32'h100 + r}); end
      tick();
      s_ack = 1'b1;
      #1;
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tie_grant_m1 round %0d: got %b expected 10", r, grant); end
      n_checks++; if ({s_we, s_adr, s_wdat} !== {1'b0, 32'h200 + r, 32'hB0 + r}) begin n_fail++; $display("FAIL tie_m1_payload round %0d: got %h expected %h", r, {s_we, s_adr, s_wdat}, {1'b0, 32'h200 + r, 32'hB0 + r}); end
      n_checks++; if ({m0_ack, m1_ack} !== 2'b01) begin n_fail++; $display("FAIL tie_m1_ack round %0d: got %b expected 01", r, {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      #1;
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_idle round %0d: got %b expected 00", r, grant); end
      $display("test_tie round %0d done", r);
    end
  endtask

  task automatic test_single();
    tick();
    drive_m0(1'b1, 32'h3000_0004, 32'h0000_00A5);
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_latency: got %b expected 00", grant); end
    tick();
    #1;
    n_checks++; if ({grant, s_cyc, s_stb, s_we} !== 5'b01111) begin n_fail++; $display("FAIL single_grant_ctl: got %b expected 01111", {grant, s_cyc, s_stb, s_we}); end
    n_checks++; if ({s_sel, s_adr, s_wdat} !== {4'hF, 32'h3000_0004, 32'h0000_00A5}) begin n_fail++; $display("FAIL single_payload: got %h expected %h", {s_sel, s_adr, s_wdat}, {4'hF, 32'h3000_0004, 32'h0000_00A5}); end
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b expected 0", m0_ack); end
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    n_checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b100) begin n_fail++; $display("FAIL single_ack: got %b expected 100", {m0_ack, m0_err, m1_ack}); end
    n_checks++; if (m0_rdat !== 32'h5A5A_0000) begin n_fail++; $display("FAIL single_rdata: got %h expected 5a5a0000", m0_rdat); end
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    n_checks++; if ({grant, m0_ack} !== 3'b010) begin n_fail++; $display("FAIL single_ack_width: got %b expected 010", {grant, m0_ack}); end
    tick();
    #1;
    n_checks++; if ({grant, s_cyc, s_stb, s_adr} !== {4'b0000, 32'h3000_0004}) begin n_fail++; $display("FAIL single_release: got %h expected %h", {grant, s_cyc, s_stb, s_adr}, {4'b0000, 32'h3000_0004}); end
    $display("test_single done");
  endtask

  task automatic test_atomic();
    tick();
    drive_m1(1'b1, 32'h10, 32'h11);
    tick();
    drive_m0(1'b1, 32'h3000_0008, 32'hCC);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1'b1;
      #1;
      n_checks++; if ({grant, s_adr} !== {2'b10, 32'h10 + i}) begin n_fail++; $display("FAIL atomic_access %0d: got %h expected %h", i, {grant, s_adr}, {2'b10, 32'h10 + i}); end
      n_checks++; if ({m0_ack, m1_ack} !== 2'b01) begin n_fail++; $display("FAIL atomic_ack %0d: got %b expected 01", i, {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m1_stb = 1'b0;
      tick();
      #1;
      n_checks++; if ({grant, s_stb} !== 3'b100) begin n_fail++; $display("FAIL atomic_gap %0d: got %b expected 100", i, {grant, s_stb}); end
      if (i < 2) begin
        m1_stb = 1'b1; m1_adr = 32'h10 + i + 1; m1_dat = 32'h11 + i + 1;
      end else begin
        m1_cyc = 1'b0;
      end
      tick();
      $display("test_atomic access %0d done", i);
    end
    #1;
    n_checks++; if ({grant, s_cyc, s_adr} !== {2'b01, 1'b1, 32'h3000_0008}) begin n_fail++; $display("FAIL atomic_switch_no_idle: got %h expected %h", {grant, s_cyc, s_adr}, {2'b01, 1'b1, 32'h3000_0008}); end
    s_ack = 1'b1;
    #1;
    n_checks++; if ({m0_ack, m1_ack} !== 2'b10) begin n_fail++; $display("FAIL atomic_m0_ack: got %b expected 10", {m0_ack, m1_ack}); end
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL atomic_idle: got %b expected 00", grant); end
  endtask

  task automatic test_ack_coincident();
    tick();
    drive_m0(1'b0, 32'h3000_000C, 32'h0);
    tick();
    repeat (10) tick();
    s_ack = 1'b1;
    #1;
    n_checks++; if ({m0_ack, m0_err} !== 2'b10) begin n_fail++; $display("FAIL coincide_ack_wins: got %b expected 10", {m0_ack, m0_err}); end
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    n_checks++; if ({tmo, s_cyc, m0_err} !== 3'b010) begin n_fail++; $display("FAIL coincide_no_abort: got %b expected 010", {tmo, s_cyc, m0_err}); end
    tick();
    #1;
    n_checks++; if ({grant, tmo} !== 3'b000) begin n_fail++; $display("FAIL coincide_idle: got %b expected 000", {grant, tmo}); end
    $display("test_ack_coincident done");
  endtask

  task automatic test_timeout();
    tick();
    drive_m0(1'b1, 32'h3000_0010, 32'h77);
    tick();
    for (int k = 0; k <= 12; k++) begin
      if (k == 5) drive_m1(1'b0, 32'h20, 32'h0);
      if (k == 12) s_ack = 1'b1;
      #1;
      if (k < 10) begin
        n_checks++; if (m0_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early_err k=%0d: got %b expected 0", k, m0_err); end
      end else if (k == 10) begin
        n_checks++; if ({m0_err, m1_err, s_cyc, s_stb, tmo} !== 5'b10110) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 10110", {m0_err, m1_err, s_cyc, s_stb, tmo}); end
      end else if (k == 11) begin
        n_checks++; if ({m0_err, s_cyc, s_stb, tmo, grant} !== 6'b000101) begin n_fail++; $display("FAIL timeout_abort: got %b expected 000101", {m0_err, s_cyc, s_stb, tmo, grant}); end
      end else begin
        n_checks++; if ({m0_ack, m1_ack, m0_err} !== 3'b000) begin n_fail++; $display("FAIL timeout_late_ack: got %b expected 000", {m0_ack, m1_ack, m0_err}); end
      end
      tick();
    end
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    #1;
    n_checks++; if ({grant, s_cyc, s_stb, s_adr} !== {4'b1011, 32'h20}) begin n_fail++; $display("FAIL timeout_m1_served: got %h expected %h", {grant, s_cyc, s_stb, s_adr}, {4'b1011, 32'h20}); end
    s_ack = 1'b1;
    #1;
    n_checks++; if ({m1_ack, m1_err} !== 2'b10) begin n_fail++; $display("FAIL timeout_m1_ack: got %b expected 10", {m1_ack, m1_err}); end
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    #1;
    n_checks++; if ({grant, tmo} !== 3'b001) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 001", {grant, tmo}); end
    $display("test_timeout done");
  endtask

  task automatic test_no_timeout();
    int nt_pulses = 0;
    int main_pulses = 0;
    tick();
    drive_m0(1'b0, 32'h3000_0014, 32'h0);
    repeat (1000) begin
      tick();
      if (nt_m0_err === 1'b1) nt_pulses++;
      if (m0_err === 1'b1) main_pulses++;
    end
    #1;
    n_checks++; if (nt_pulses != 0) begin n_fail++; $display("FAIL nt_no_err: got %0d pulses expected 0", nt_pulses); end
    n_checks++; if ({nt_s_cyc, nt_s_stb, nt_tmo} !== 3'b110) begin n_fail++; $display("FAIL nt_still_active: got %b expected 110", {nt_s_cyc, nt_s_stb, nt_tmo}); end
    n_checks++; if (main_pulses != 1) begin n_fail++; $display("FAIL main_single_err_pulse: got %0d pulses expected 1", main_pulses); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();
    #1;
    n_checks++; if ({grant, nt_grant} !== 4'b0000) begin n_fail++; $display("FAIL nt_release: got %b expected 0000", {grant, nt_grant}); end
    $display("test_no_timeout done");
  endtask

  task automatic test_reset_mid();
    tick();
    drive_m1(1'b1, 32'h40, 32'h44);
    tick();
    #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre_grant: got %b expected 10", grant); end
    rst = 1'b1; s_ack = 1'b1;
    tick();
    #1;
    n_checks++; if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat} !== 71'h0) begin n_fail++; $display("FAIL rstmid_slave: got %h expected 0", {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat}); end
    n_checks++; if ({grant, tmo, nt_grant} !== 5'b00000) begin n_fail++; $display("FAIL rstmid_grant_tmo: got %b expected 00000", {grant, tmo, nt_grant}); end
    n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack_err: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    rst = 1'b0; s_ack = 1'b0;
    drive_m0(1'b0, 32'h50, 32'h0);
    tick();
    #1;
    n_checks++; if ({grant, s_adr} !== {2'b01, 32'h50}) begin n_fail++; $display("FAIL rstmid_first_tie_m0: got %h expected %h", {grant, s_adr}, {2'b01, 32'h50}); end
    idle_inputs();
    tick();
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    s_rdat = 32'h5A5A_0000;
    test_reset();
    test_tie();
    test_single();
    test_atomic();
    test_ack_coincident();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit: got no finish expected finish before limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
